dac_playback_buffer: RTL and testbench
======================================

Name: dac_playback_buffer

Overview:
- Transmit-side counterpart of the ADC smoothing capture path.
- Host loads I/Q samples one at a time into an internal buffer. On startFlag, the block replays them to the DAC, one sample per iq_re strobe, either once or looped.
- Sits between the host register interface and the DAC data bus.

Parameters:
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples
IDLE_CODE, 16'h0000, value driven on dac_dataI/dac_dataQ when not playing

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
writeFlag  in  1  one-cycle pulse; write {host_i,host_q} at the load pointer
host_i  in  16  I sample to load
host_q  in  16  Q sample to load
clearFlag  in  1  one-cycle pulse; empty the buffer (IDLE only)
startFlag  in  1  one-cycle pulse; begin playback
stopFlag  in  1  one-cycle pulse; abort playback
loop  in  1  1 = wrap to sample 0 after the last sample; sampled at start
iq_re  in  1  DAC sample strobe; may be asserted every cycle
dac_dataI  out  16  I sample to DAC
dac_dataQ  out  16  Q sample to DAC
playing  out  1  high in PRIME and PLAY
count  out  ADDR_W+1  number of samples loaded
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky; a write was attempted while full

Behaviour:
- Reset:
  - state=IDLE; count=0; rd_ptr=0.
  - dac_dataI = dac_dataQ = IDLE_CODE.
  - playing=0; full=0; empty=1; overflow=0.
  - Buffer contents are undefined.
  - Reset mid-playback aborts immediately with these same values.
- Storage: DEPTH x 32-bit RAM holding {I,Q}.
  - One write port.
  - Synchronous read port addressed by the next-state value of rd_ptr, so the RAM output equals buf[rd_ptr] in every cycle of PLAY.
- IDLE:
  - writeFlag with count<DEPTH: buf[count] <= {host_i,host_q}; count++.
  - writeFlag with count==DEPTH: write dropped; overflow<=1.
  - clearFlag: count<=0 and overflow<=0. clearFlag beats writeFlag and startFlag in the same cycle.
  - startFlag with count>0 (count after any same-cycle write): latch loop into loop_r; rd_ptr<=0; go to PRIME.
  - startFlag with count==0: ignored.
  - iq_re: outputs <= IDLE_CODE.
- PRIME: single cycle; RAM read of address 0 is in flight; go to PLAY unconditionally. An iq_re during PRIME is ignored and leaves the outputs unchanged.
- PLAY, on iq_re:
  - dac_dataI/Q <= buf[rd_ptr] (1-cycle latency from strobe to output).
  - If rd_ptr == count-1: if loop_r, rd_ptr<=0 and stay in PLAY; else go to IDLE, holding the last sample until the next iq_re (which drives IDLE_CODE).
  - Otherwise rd_ptr++.
  - Back-to-back strobes every cycle yield consecutive samples with no bubbles.
- PLAY without iq_re: outputs hold.
- writeFlag and clearFlag outside IDLE are ignored; they neither change count nor set overflow.
- stopFlag in PRIME/PLAY: go to IDLE; outputs <= IDLE_CODE on the next edge. stopFlag beats a same-cycle iq_re.
- count=1 looping: the single sample repeats on every strobe.
- full and empty are combinational from count.

Decomposition:
- Shared package: state encoding (IDLE, PRIME, PLAY), default IDLE_CODE, sample width 16.
- One sub-module: playback_ram, a simple dual-port RAM (1 write port, 1 synchronous read port, width 32, depth 2**ADDR_W); infers block RAM.

Test Plan:
- Load 4 samples (I=16'h0001..0004, Q=16'h1001..1004), loop=0, start, iq_re every cycle -> outputs 0001/1001..0004/1004 on consecutive cycles starting 1 cycle after the first post-PRIME strobe. Next strobe -> IDLE_CODE; playing falls after the 4th sample.
- Same load, loop=1, iq_re every 3rd cycle for 10 strobes -> sequence 1,2,3,4,1,2,3,4,1,2. stopFlag -> outputs 0000 next cycle, playing=0.
- Write DEPTH+2 samples -> full=1, count=DEPTH, overflow=1. clearFlag -> count=0, empty=1, overflow=0.
- startFlag with empty buffer -> playing stays 0, outputs stay IDLE_CODE.
- writeFlag during PLAY -> count unchanged. Same-cycle clearFlag+startFlag in IDLE -> count=0, no playback.
- rst asserted mid-PLAY -> next cycle outputs IDLE_CODE, playing=0, count=0. A subsequent load+start plays correctly.

Source files
------------

// File: rtl/dac_playback_buffer_pkg.sv
// Shared types and defaults for the DAC playback buffer.
// Holds the playback state encoding and sample sizing.
package dac_playback_buffer_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 2 * SAMPLE_W;

    localparam logic [SAMPLE_W-1:0] DEF_IDLE_CODE = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } pb_state_e;

endpackage

// File: rtl/dac_playback_buffer_playback_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// No reset on the array so it maps onto block RAM.
module playback_ram
    import dac_playback_buffer_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Synchronous read port (read-before-write on collision)
    always_ff @(posedge clk) begin
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/dac_playback_buffer.sv
// Host-loaded I/Q sample buffer replayed to the DAC on iq_re strobes.
// Supports single-shot and looped playback with a one-cycle prime.
module dac_playback_buffer
    import dac_playback_buffer_pkg::*;
#(
    parameter int                   ADDR_W    = 10,
    parameter logic [SAMPLE_W-1:0]  IDLE_CODE = DEF_IDLE_CODE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                writeFlag,
    input  logic [SAMPLE_W-1:0] host_i,
    input  logic [SAMPLE_W-1:0] host_q,
    input  logic                clearFlag,
    input  logic                startFlag,
    input  logic                stopFlag,
    input  logic                loop,
    input  logic                iq_re,
    output logic [SAMPLE_W-1:0] dac_dataI,
    output logic [SAMPLE_W-1:0] dac_dataQ,
    output logic                playing,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty,
    output logic                overflow
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    pb_state_e           state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                loop_q, loop_d;
    logic                ovf_q, ovf_d;
    logic [SAMPLE_W-1:0] dac_i_q, dac_i_d;
    logic [SAMPLE_W-1:0] dac_q_q, dac_q_d;
    logic                we;
    logic [WORD_W-1:0]   ram_rd;
    logic                last;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign playing  = (state_q != IDLE);
    assign dac_dataI = dac_i_q;
    assign dac_dataQ = dac_q_q;

    assign last = ({1'b0, rd_ptr_q} == (count_q - (ADDR_W+1)'(1)));

    // The RAM is addressed with next-state rd_ptr so its output tracks rd_ptr
    playback_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (count_q[ADDR_W-1:0]),
        .wdata_i ({host_i, host_q}),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rd)
    );

    // Next-state logic for load, control and playback
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        loop_d   = loop_q;
        ovf_d    = ovf_q;
        dac_i_d  = dac_i_q;
        dac_q_d  = dac_q_q;
        we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clearFlag) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    if (writeFlag) begin
                        if (!full) begin
                            we      = 1'b1;
                            count_d = count_q + (ADDR_W+1)'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (startFlag && (count_d != '0)) begin
                        loop_d   = loop;
                        rd_ptr_d = '0;
                        state_d  = PRIME;
                    end
                end
                if (iq_re) begin
                    dac_i_d = IDLE_CODE;
                    dac_q_d = IDLE_CODE;
                end
            end
            PRIME: begin
                if (stopFlag) begin
                    state_d = IDLE;
                    dac_i_d = IDLE_CODE;
                    dac_q_d = IDLE_CODE;
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (stopFlag) begin
                    state_d = IDLE;
                    dac_i_d = IDLE_CODE;
                    dac_q_d = IDLE_CODE;
                end else if (iq_re) begin
                    dac_i_d = ram_rd[WORD_W-1:SAMPLE_W];
                    dac_q_d = ram_rd[SAMPLE_W-1:0];
                    if (last) begin
                        if (loop_q) begin
                            rd_ptr_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            loop_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dac_i_q  <= IDLE_CODE;
            dac_q_q  <= IDLE_CODE;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            loop_q   <= loop_d;
            ovf_q    <= ovf_d;
            dac_i_q  <= dac_i_d;
            dac_q_q  <= dac_q_d;
        end
    end

endmodule

// File: tb/tb_dac_playback_buffer.sv
// Randomised and directed bench for dac_playback_buffer.
// A queue-based playback model predicts every output each cycle.
module tb_dac_playback_buffer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [15:0] IDLE_C = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        writeFlag = 1'b0;
    logic [15:0] host_i = '0;
    logic [15:0] host_q = '0;
    logic        clearFlag = 1'b0;
    logic        startFlag = 1'b0;
    logic        stopFlag = 1'b0;
    logic        loop = 1'b0;
    logic        iq_re = 1'b0;
    logic [15:0] dac_dataI;
    logic [15:0] dac_dataQ;
    logic        playing;
    logic [ADDR_W:0] count;
    logic        full;
    logic        empty;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // model: samples held in a queue, playback mode 0=idle 1=prime 2=play
    logic [31:0] m_buf [$];
    int          m_mode = 0;
    int          m_pos = 0;
    bit          m_loop = 0;
    bit          m_ovf = 0;
    logic [15:0] m_i = IDLE_C;
    logic [15:0] m_q = IDLE_C;

    dac_playback_buffer #(
        .ADDR_W    (ADDR_W),
        .IDLE_CODE (IDLE_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .writeFlag (writeFlag),
        .host_i    (host_i),
        .host_q    (host_q),
        .clearFlag (clearFlag),
        .startFlag (startFlag),
        .stopFlag  (stopFlag),
        .loop      (loop),
        .iq_re     (iq_re),
        .dac_dataI (dac_dataI),
        .dac_dataQ (dac_dataQ),
        .playing   (playing),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_mode = 0;
            m_pos  = 0;
            m_ovf  = 0;
            m_buf.delete();
            m_i = IDLE_C;
            m_q = IDLE_C;
        end else if (m_mode == 0) begin
            if (clearFlag) begin
                m_buf.delete();
                m_ovf = 0;
            end else begin
                if (writeFlag) begin
                    if (m_buf.size() < DEPTH) m_buf.push_back({host_i, host_q});
                    else m_ovf = 1;
                end
                if (startFlag && m_buf.size() > 0) begin
                    m_loop = loop;
                    m_pos  = 0;
                    m_mode = 1;
                end
            end
            if (iq_re) begin
                m_i = IDLE_C;
                m_q = IDLE_C;
            end
        end else if (stopFlag) begin
            m_mode = 0;
            m_i = IDLE_C;
            m_q = IDLE_C;
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (iq_re) begin
            {m_i, m_q} = m_buf[m_pos];
            m_pos++;
            if (m_pos == m_buf.size()) begin
                m_pos = 0;
                if (!m_loop) m_mode = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("dacI", 32'(dac_dataI), 32'(m_i));
        chk("dacQ", 32'(dac_dataQ), 32'(m_q));
        chk("playing", 32'(playing), 32'(m_mode != 0));
        chk("count", 32'(count), 32'(m_buf.size()));
        chk("full", 32'(full), 32'(m_buf.size() == DEPTH));
        chk("empty", 32'(empty), 32'(m_buf.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        rst = 0; writeFlag = 0; clearFlag = 0;
        startFlag = 0; stopFlag = 0; iq_re = 0;
    endtask

    task automatic load4();
        for (int k = 1; k <= 4; k++) begin
            writeFlag = 1;
            host_i = 16'(k);
            host_q = 16'h1000 + 16'(k);
            tick();
        end
    endtask

    initial begin
        rst = 1; tick();
        rst = 1; tick();
        tick();

        // single shot, strobe every cycle
        load4();
        loop = 0; startFlag = 1; tick();
        for (int n = 0; n < 8; n++) begin iq_re = 1; tick(); end

        // looped, strobe every third cycle, then stop
        loop = 1; startFlag = 1; tick();
        for (int n = 0; n < 30; n++) begin iq_re = (n % 3 == 0); tick(); end
        stopFlag = 1; iq_re = 1; tick();
        chk("stop_playing", 32'(playing), 32'd0);
        chk("stop_dacI", 32'(dac_dataI), 32'(IDLE_C));
        tick();

        // overflow and clear
        clearFlag = 1; tick();
        for (int n = 0; n < DEPTH + 2; n++) begin
            writeFlag = 1; host_i = 16'($urandom); host_q = 16'($urandom); tick();
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), DEPTH);
        chk("ovf_flag", 32'(overflow), 32'd1);
        clearFlag = 1; writeFlag = 1; tick();
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // start with empty buffer
        startFlag = 1; iq_re = 1; tick();
        tick();
        chk("empty_start", 32'(playing), 32'd0);

        // writes and clears during play are ignored
        load4();
        loop = 1; startFlag = 1; tick();
        for (int n = 0; n < 6; n++) begin
            iq_re = 1; writeFlag = (n % 2 == 0); clearFlag = (n == 3); tick();
        end
        stopFlag = 1; tick();

        // clear beats start
        clearFlag = 1; startFlag = 1; tick();
        tick();
        chk("clr_start", 32'(playing), 32'd0);

        // reset mid-play, then replay
        load4();
        loop = 0; startFlag = 1; tick();
        for (int n = 0; n < 3; n++) begin iq_re = 1; tick(); end
        rst = 1; iq_re = 1; tick();
        chk("rst_count", 32'(count), 32'd0);
        load4();
        loop = 0; startFlag = 1; tick();
        for (int n = 0; n < 7; n++) begin iq_re = 1; tick(); end

        // single sample looping; write+start same cycle
        clearFlag = 1; tick();
        writeFlag = 1; host_i = 16'hABCD; host_q = 16'h1234;
        loop = 1; startFlag = 1; tick();
        for (int n = 0; n < 6; n++) begin iq_re = 1; tick(); end
        stopFlag = 1; tick();

        // stop while priming
        startFlag = 1; tick();
        stopFlag = 1; tick();
        tick();

        // random mix
        for (int n = 0; n < 6000; n++) begin
            rst       = ($urandom_range(0, 999) < 2);
            writeFlag = ($urandom_range(0, 99) < 30);
            host_i    = 16'($urandom);
            host_q    = 16'($urandom);
            clearFlag = ($urandom_range(0, 99) < 2);
            startFlag = ($urandom_range(0, 99) < 6);
            stopFlag  = ($urandom_range(0, 199) < 2);
            loop      = 1'($urandom_range(0, 1));
            iq_re     = ($urandom_range(0, 99) < 60);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
